key_entry_controller: RTL and testbench
=======================================

KEY_ENTRY_CONTROLLER -- requirements
Module: key_entry_controller

Interface
REQ-001 SHALL have ports: clk  input  1  single system clock; all logic on its rising edge.
REQ-002 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: key_valid  input  1  one-cycle pulse from the PS/2 decoder on any make or break.
REQ-004 SHALL have ports: last_change  input  9  scan code of the event; bit 8 = E0-extended.
REQ-005 SHALL have ports: key_down  input  512  held-key bitmap from the decoder.
REQ-006 SHALL have ports: entry_ready  input  1  consumer accepts the presented entry.
REQ-007 SHALL have ports: entry  output  16  four BCD digits; [3:0] = most recent digit.
REQ-008 SHALL have ports: entry_valid  output  1  entry is complete and stable.
REQ-009 SHALL have ports: digit_count  output  3  digits buffered, 0..4.
REQ-010 SHALL have ports: overflow  output  1  sticky; a digit was dropped because the buffer was full.
REQ-011 SHALL have ports: key_num  output  4  last accepted digit, for the 7-seg path.

Function
REQ-012 A press event SHALL be key_valid=1 AND key_down[last_change]=1; break events SHALL only update the hold tracker (REQ-014).
REQ-013 Decode SHALL be:
  - digits (bit8=0): 0x45=0, 0x16=1, 0x1E=2, 0x26=3, 0x25=4, 0x2E=5, 0x36=6, 0x3D=7, 0x3E=8, 0x46=9
  - ENTER: 0x05A or 0x15A
  - BKSP: 0x066
  - ESC: 0x076
  - all other codes SHALL be ignored.
REQ-014 Typematic suppression:
  - a held_code register SHALL record the last press code and SHALL clear on a break of that code;
  - a press whose code equals held_code SHALL be ignored.
REQ-015 FSM SHALL have two states, COLLECT and PRESENT; reset state SHALL be COLLECT.
REQ-016 In COLLECT, a digit with count<4 SHALL:
  - set entry <= {entry[11:0], d};
  - increment count;
  - set key_num <= d;
  - all updated on the clock edge after the event.
REQ-017 In COLLECT, a digit with count=4 SHALL:
  - leave entry and count unchanged;
  - set overflow=1;
  - still update key_num.
REQ-018 In COLLECT, BKSP with count>0 SHALL:
  - set entry <= {4'h0, entry[15:4]};
  - decrement count;
  - with count=0, BKSP SHALL be a no-op.
REQ-019 ESC in either state SHALL clear entry, count and overflow, and SHALL return to COLLECT.
REQ-020 In COLLECT, ENTER with count>0 SHALL move the FSM to PRESENT, with entry_valid=1 from the next cycle; ENTER with count=0 SHALL be ignored.
REQ-021 In PRESENT:
  - entry, digit_count and overflow SHALL stay stable;
  - all events except ESC SHALL be dropped, but the hold tracker SHALL still update.
REQ-022 In PRESENT, entry_valid AND entry_ready in the same cycle SHALL be the handshake; the next cycle SHALL have state COLLECT, entry=0, count=0, overflow=0, entry_valid=0.
REQ-023 If the handshake and ESC occur in the same cycle, the handshake SHALL be counted as completed; the resulting state is identical to REQ-022.
REQ-024 entry_ready SHALL be ignored while entry_valid=0.
REQ-025 entry_valid SHALL be a registered output equal to (state==PRESENT).

Reset
REQ-026 A cycle with rst=1 SHALL set state=COLLECT, entry=0, digit_count=0, entry_valid=0, overflow=0, key_num=0, held_code=0x000.
REQ-027 Reset asserted mid-entry or during PRESENT SHALL discard buffered digits, with no handshake completed.
REQ-028 Events coincident with rst=1 SHALL be ignored.

Verification
REQ-029 Press 1,2,3 (make/break each), then ENTER, then entry_ready=1 for one cycle:
  - entry=0x0123 and digit_count=3 during PRESENT;
  - entry_valid=1 exactly one cycle after the ENTER pulse;
  - all outputs 0 after the handshake.
REQ-030 Press 5 digits 9,8,7,6,5: entry=0x9876, digit_count=4, overflow=1, key_num=5.
REQ-031 Digits 4,7, BKSP, BKSP, BKSP, ENTER: entry 0x0047 -> 0x0004 -> 0x0000; count stays 0 after the third BKSP; ENTER gives no entry_valid.
REQ-032 Make 0x16 three times without a break, then break, then make: count=2 and entry=0x0011.
REQ-033 Enter 0x0042 with entry_ready held 0, press 7 during PRESENT, then ESC together with entry_ready=1: entry stays 0x0042 while waiting; the next cycle has state COLLECT and all fields 0.
REQ-034 Assert rst for one cycle during PRESENT with entry=0x0031: next cycle entry_valid=0, entry=0, digit_count=0.

Source files
------------

// File: rtl/key_entry_controller.sv
// Collects up to four BCD digits from PS/2 key events and presents them as one entry.
// Latency: outputs update on the clock edge after the key event or handshake.
// Backpressure: a presented entry is held stable until entry_ready (or ESC) releases it.
module key_entry_controller (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [8:0]   last_change,
  input  logic [511:0] key_down,
  input  logic         entry_ready,
  output logic [15:0]  entry,
  output logic         entry_valid,
  output logic [2:0]   digit_count,
  output logic         overflow,
  output logic [3:0]   key_num
);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [15:0] entry_q, entry_d;
  logic [2:0]  count_q, count_d;
  logic        overflow_q, overflow_d;
  logic [3:0]  key_num_q, key_num_d;
  logic        entry_valid_q, entry_valid_d;
  logic [8:0]  held_code_q, held_code_d;

  logic       is_digit, is_enter, is_bksp, is_esc;
  logic [3:0] digit_val;
  logic       press, brk, press_new, handshake;

  // Classify the scan code of the current event.
  always_comb begin
    is_digit  = 1'b0;
    is_enter  = 1'b0;
    is_bksp   = 1'b0;
    is_esc    = 1'b0;
    digit_val = 4'd0;
    case (last_change)
      9'h045: begin is_digit = 1'b1; digit_val = 4'd0; end
      9'h016: begin is_digit = 1'b1; digit_val = 4'd1; end
      9'h01E: begin is_digit = 1'b1; digit_val = 4'd2; end
      9'h026: begin is_digit = 1'b1; digit_val = 4'd3; end
      9'h025: begin is_digit = 1'b1; digit_val = 4'd4; end
      9'h02E: begin is_digit = 1'b1; digit_val = 4'd5; end
      9'h036: begin is_digit = 1'b1; digit_val = 4'd6; end
      9'h03D: begin is_digit = 1'b1; digit_val = 4'd7; end
      9'h03E: begin is_digit = 1'b1; digit_val = 4'd8; end
      9'h046: begin is_digit = 1'b1; digit_val = 4'd9; end
      9'h05A, 9'h15A: is_enter = 1'b1;
      9'h066: is_bksp = 1'b1;
      9'h076: is_esc  = 1'b1;
      default: ;
    endcase
  end

  // Make/break qualification; a repeat make of the held key is typematic and dropped.
  always_comb begin
    press     = key_valid && key_down[last_change];
    brk       = key_valid && !key_down[last_change];
    press_new = press && (last_change != held_code_q);
    handshake = entry_valid_q && entry_ready;
    held_code_d = held_code_q;
    if (press)
      held_code_d = last_change;
    else if (brk && (last_change == held_code_q))
      held_code_d = 9'h000;
  end

  // Entry buffer and COLLECT/PRESENT sequencing; handshake wins over a coincident ESC.
  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    key_num_d  = key_num_q;
    if (handshake) begin
      state_d    = ST_COLLECT;
      entry_d    = 16'h0000;
      count_d    = 3'd0;
      overflow_d = 1'b0;
      key_num_d  = 4'd0;
    end else if (press_new && is_esc) begin
      state_d    = ST_COLLECT;
      entry_d    = 16'h0000;
      count_d    = 3'd0;
      overflow_d = 1'b0;
    end else if (press_new && (state_q == ST_COLLECT)) begin
      if (is_digit) begin
        key_num_d = digit_val;
        if (count_q < 3'd4) begin
          entry_d = {entry_q[11:0], digit_val};
          count_d = count_q + 3'd1;
        end else begin
          overflow_d = 1'b1;
        end
      end else if (is_bksp && (count_q != 3'd0)) begin
        entry_d = {4'h0, entry_q[15:4]};
        count_d = count_q - 3'd1;
      end else if (is_enter && (count_q != 3'd0)) begin
        state_d = ST_PRESENT;
      end
    end
    entry_valid_d = (state_d == ST_PRESENT);
  end

  // State registers with synchronous reset; events in a reset cycle are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_COLLECT;
      entry_q       <= 16'h0000;
      count_q       <= 3'd0;
      overflow_q    <= 1'b0;
      key_num_q     <= 4'd0;
      entry_valid_q <= 1'b0;
      held_code_q   <= 9'h000;
    end else begin
      state_q       <= state_d;
      entry_q       <= entry_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      key_num_q     <= key_num_d;
      entry_valid_q <= entry_valid_d;
      held_code_q   <= held_code_d;
    end
  end

  assign entry       = entry_q;
  assign entry_valid = entry_valid_q;
  assign digit_count = count_q;
  assign overflow    = overflow_q;
  assign key_num     = key_num_q;

endmodule

// File: tb/tb_key_entry_controller.sv
// Bench for key_entry_controller: directed scenarios then random key traffic vs a queue model.
module tb_key_entry_controller;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_valid = 1'b0;
  logic [8:0]   last_change = 9'h000;
  logic [511:0] key_down = '0;
  logic         entry_ready = 1'b0;
  logic [15:0]  entry;
  logic         entry_valid;
  logic [2:0]   digit_count;
  logic         overflow;
  logic [3:0]   key_num;

  int tests = 0;
  int fails = 0;

  key_entry_controller dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
    .key_down(key_down), .entry_ready(entry_ready), .entry(entry),
    .entry_valid(entry_valid), .digit_count(digit_count), .overflow(overflow),
    .key_num(key_num)
  );

  always #5 clk = ~clk;

  localparam logic [8:0] DIG_CODES [10] = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025,
                                            9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046};
  localparam logic [8:0] POOL [14] = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025,
                                       9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046,
                                       9'h05A, 9'h15A, 9'h066, 9'h076};

  // Reference model: buffered digits oldest-first, plus presentation flag.
  int         mq[$];
  bit         mpres = 0;
  bit         movf = 0;
  int         mknum = 0;
  logic [8:0] mheld = 9'h000;

  function automatic int digit_of(input logic [8:0] c);
    for (int i = 0; i < 10; i++) if (DIG_CODES[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [15:0] model_entry();
    int e = 0;
    foreach (mq[i]) e = (e << 4) | mq[i];
    return e[15:0];
  endfunction

  task automatic model_clear();
    mq.delete();
    mpres = 0;
    movf  = 0;
  endtask

  task automatic model_update(input bit kv, input logic [8:0] code, input bit down,
                              input bit rdy, input bit r);
    bit press, newp, hs;
    int d;
    if (r) begin
      model_clear();
      mknum = 0;
      mheld = 9'h000;
    end else begin
      press = kv && down;
      newp  = press && (code != mheld);
      hs    = mpres && rdy;
      if (press) mheld = code;
      else if (kv && !down && code == mheld) mheld = 9'h000;
      if (hs) begin
        model_clear();
        mknum = 0;
      end else if (newp) begin
        d = digit_of(code);
        if (code == 9'h076) model_clear();
        else if (!mpres) begin
          if (d >= 0) begin
            mknum = d;
            if (mq.size() < 4) mq.push_back(d);
            else movf = 1;
          end else if (code == 9'h066 && mq.size() > 0) begin
            void'(mq.pop_back());
          end else if ((code == 9'h05A || code == 9'h15A) && mq.size() > 0) begin
            mpres = 1;
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".entry"}, entry, model_entry());
    check({tag, ".valid"}, {15'd0, entry_valid}, {15'd0, mpres});
    check({tag, ".count"}, {13'd0, digit_count}, mq.size());
    check({tag, ".ovf"}, {15'd0, overflow}, {15'd0, movf});
    check({tag, ".keynum"}, {12'd0, key_num}, mknum);
  endtask

  // One clock: present inputs, let the edge happen, advance the model, compare.
  task automatic step(input bit kv, input logic [8:0] code, input bit rdy, input bit r,
                      input string tag);
    key_valid   = kv;
    last_change = code;
    entry_ready = rdy;
    rst         = r;
    @(posedge clk);
    model_update(kv, code, key_down[code], rdy, r);
    #1;
    check_model(tag);
    key_valid   = 1'b0;
    entry_ready = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic make(input logic [8:0] code, input bit rdy, input string tag);
    key_down[code] = 1'b1;
    step(1'b1, code, rdy, 1'b0, tag);
  endtask

  task automatic brk(input logic [8:0] code, input string tag);
    key_down[code] = 1'b0;
    step(1'b1, code, 1'b0, 1'b0, tag);
  endtask

  task automatic tap(input logic [8:0] code, input string tag);
    make(code, 1'b0, tag);
    brk(code, tag);
  endtask

  initial begin
    // Reset values
    step(1'b0, 9'h000, 1'b0, 1'b1, "reset");
    check("reset.entry_const", entry, 16'h0000);

    // Basic entry and handshake
    tap(9'h016, "d1");
    tap(9'h01E, "d2");
    tap(9'h026, "d3");
    check("seq.valid_before_enter", {15'd0, entry_valid}, 16'd0);
    make(9'h05A, 1'b0, "enter");
    check("seq.valid_after_enter", {15'd0, entry_valid}, 16'd1);
    check("seq.entry", entry, 16'h0123);
    check("seq.count", {13'd0, digit_count}, 16'd3);
    brk(9'h05A, "enter_brk");
    step(1'b0, 9'h000, 1'b1, 1'b0, "handshake");
    check("hs.all_zero", {entry, entry_valid, digit_count, overflow, key_num}, 16'h0);

    // Overflow: five digits into a four-digit buffer
    tap(9'h046, "o9"); tap(9'h03E, "o8"); tap(9'h03D, "o7");
    tap(9'h036, "o6"); tap(9'h02E, "o5");
    check("ovf.entry", entry, 16'h9876);
    check("ovf.count", {13'd0, digit_count}, 16'd4);
    check("ovf.flag", {15'd0, overflow}, 16'd1);
    check("ovf.keynum", {12'd0, key_num}, 16'd5);
    tap(9'h076, "ovf_esc");
    check("esc.ovf_clear", {15'd0, overflow}, 16'd0);

    // Backspace down to empty; ENTER on empty buffer
    tap(9'h025, "b4"); tap(9'h03D, "b7");
    check("bksp.start", entry, 16'h0047);
    tap(9'h066, "bk1");
    check("bksp.one", entry, 16'h0004);
    tap(9'h066, "bk2");
    check("bksp.two", entry, 16'h0000);
    tap(9'h066, "bk3");
    check("bksp.empty_count", {13'd0, digit_count}, 16'd0);
    tap(9'h05A, "enter_empty");
    check("bksp.no_valid", {15'd0, entry_valid}, 16'd0);

    // Typematic repeats suppressed
    make(9'h016, 1'b0, "t1"); make(9'h016, 1'b0, "t2"); make(9'h016, 1'b0, "t3");
    brk(9'h016, "tb");
    make(9'h016, 1'b0, "t4");
    check("typ.count", {13'd0, digit_count}, 16'd2);
    check("typ.entry", entry, 16'h0011);
    brk(9'h016, "tb2");
    tap(9'h076, "typ_esc");

    // Presentation hold, then ESC coincident with handshake
    tap(9'h025, "p4"); tap(9'h01E, "p2"); tap(9'h15A, "penter");
    step(1'b0, 9'h000, 1'b0, 1'b0, "wait1");
    step(1'b0, 9'h000, 1'b0, 1'b0, "wait2");
    check("pres.hold", entry, 16'h0042);
    tap(9'h03D, "pres7");
    check("pres.drop7", entry, 16'h0042);
    check("pres.valid", {15'd0, entry_valid}, 16'd1);
    make(9'h076, 1'b1, "esc_hs");
    check("eschs.all_zero", {entry, entry_valid, digit_count, overflow, key_num}, 16'h0);
    brk(9'h076, "esc_brk");

    // Reset during presentation
    tap(9'h026, "r3"); tap(9'h016, "r1"); tap(9'h05A, "renter");
    check("rst.pre_entry", entry, 16'h0031);
    step(1'b0, 9'h000, 1'b0, 1'b1, "rst_pres");
    check("rst.valid", {15'd0, entry_valid}, 16'd0);
    check("rst.entry", entry, 16'h0000);
    check("rst.count", {13'd0, digit_count}, 16'd0);

    // Random key traffic
    for (int n = 0; n < 600; n++) begin
      logic [8:0] code;
      int sel;
      bit kv, r, rdy;
      sel  = $urandom_range(0, 15);
      code = (sel < 14) ? POOL[sel] : 9'($urandom_range(0, 511));
      kv   = ($urandom_range(0, 3) != 0);
      rdy  = ($urandom_range(0, 3) == 0);
      r    = ($urandom_range(0, 99) == 0);
      if (kv) begin
        if (key_down[code] && $urandom_range(0, 1) == 1) key_down[code] = 1'b0;
        else key_down[code] = 1'b1;
      end
      step(kv, code, rdy, r, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
